// File: rtl/edge_capture_unit_pkg.sv
// edge_capture_unit_pkg: shared width default and falling-edge helper
package edge_capture_unit_pkg;
  localparam int ECU_WIDTH = 32;
  function automatic logic fall(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction
endpackage

// File: rtl/edge_capture_bit.sv
// edge_capture_bit: 1-bit sticky falling-edge cell
//   clk_i  clock
//   rst_ni async active-low clear of the sticky flag
//   d_i    monitored bit
//   flag_o sticky capture flag
module edge_capture_bit
  import edge_capture_unit_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic flag_o
);
  logic prev_q, cap_q, cap_d;
  assign cap_d  = cap_q | fall(prev_q, d_i);
  assign flag_o = cap_q;
  // history keeps loading during reset so the first edge after release can capture
  always_ff @(posedge clk_i) prev_q <= d_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cap_q <= 1'b0;
    else         cap_q <= cap_d;
endmodule

// File: rtl/edge_capture_unit.sv
// edge_capture_unit: per-bit sticky falling-edge detector
//   clk   clock
//   reset async active-low reset
//   in    monitored bus
//   out   sticky capture flags (registered)
module edge_capture_unit
  import edge_capture_unit_pkg::*;
#(
  parameter int WIDTH = ECU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  for (genvar j = 0; j < WIDTH; j++) begin : g_bit
    edge_capture_bit u_bit (
      .clk_i (clk),
      .rst_ni(reset),
      .d_i   (in[j]),
      .flag_o(out[j])
    );
  end
endmodule

// File: tb/tb_edge_capture_unit.sv
// tb_edge_capture_unit: directed and model-checked test of edge_capture_unit
module tb_edge_capture_unit;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] in = '0, out;
  logic [31:0] m_prev = '0, m_cap = '0;
  int pass_n = 0, total_n = 0;
  edge_capture_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .in(in), .out(out));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic tick(input logic [31:0] v, input string tag, input bit do_chk = 1'b1);
    @(negedge clk);
    in = v;
    @(posedge clk);
    m_cap  = reset ? (m_cap | (m_prev & ~in)) : 32'h0;
    m_prev = in;
    #1;
    if (do_chk) chk(tag, out, m_cap);
  endtask
  task automatic rst_pulse(input logic [31:0] v);
    @(negedge clk);
    reset = 1'b0;
    m_cap = '0;
    #1 chk("rst_async", out, 32'h0);
    tick(v, "rst_hold");
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    tick(32'h1234_5678, "s1_a", 1'b0);
    chk("s1_a0", out, 32'h0);
    tick(32'h0000_0000, "s1_b");
    tick(32'hFFFF_FFFF, "s1_c");
    tick(32'h0000_0000, "s1_d");
    chk("s1_d0", out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(32'hFFFF_FFFF, "s2_hi");
    tick(32'h0000_0000, "s2_fall");
    chk("s2_all", out, 32'hFFFF_FFFF);
    tick(32'hFFFF_FFFF, "s2_rise");
    tick(32'h5A5A_0000, "s2_mix");
    chk("s2_stick", out, 32'hFFFF_FFFF);
    rst_pulse(32'h0000_0000);
    tick(32'h0000_FFFF, "s3_rise");
    chk("s3_rise0", out, 32'h0);
    tick(32'h0000_00F0, "s3_fall");
    chk("s3_val", out, 32'h0000_FF0F);
    tick(32'h0000_00F0, "s3_steady");
    rst_pulse(32'hA5A5_A5A5);
    tick(32'h0000_0000, "s4_set");
    chk("s4_a5", out, 32'hA5A5_A5A5);
    @(posedge clk);
    #2 reset = 1'b0;
    m_cap = '0;
    #1 chk("s4_async", out, 32'h0);
    #1 reset = 1'b1;
    tick(32'h0000_0000, "s4_steady1");
    tick(32'h0000_0000, "s4_steady2");
    chk("s4_zero", out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    m_cap = '0;
    tick(32'hF0F0_1234, "s5_rst");
    @(negedge clk);
    reset = 1'b1;
    tick(32'h0000_0000, "s5_first");
    chk("s5_val", out, 32'hF0F0_1234);
    tick(32'hFFFF_FFFF, "s7_hi");
    @(negedge clk);
    reset = 1'b0;
    m_cap = '0;
    tick(32'h0000_0000, "s7_same_edge");
    chk("s7_rstwins", out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(32'hFFFF_FFFF, "s8_hi");
    tick({16'hxxxx, 16'h0000}, "s8_x", 1'b0);
    chk("s8_x_iso", out & 32'h0000_FFFF, 32'h0000_FFFF);
    rst_pulse(32'h0000_0000);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        @(negedge clk);
        reset = 1'b0;
        m_cap = '0;
        #1 chk("s6_async", out, 32'h0);
      end
      if (i == 10) begin
        @(negedge clk);
        reset = 1'b1;
      end
      tick($urandom, $sformatf("s6_v%0d", i));
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
